// File: rtl/noc_pkg.sv
// Shared flit layout and helpers for the NoC injection path.
package noc_pkg;

  localparam int unsigned FLIT_W    = 20;
  localparam int unsigned NODE_ID_W = 4;
  localparam int unsigned SRC_W     = 8;

  localparam int unsigned SRC_MSB = 19;
  localparam int unsigned SRC_LSB = 12;
  localparam int unsigned DST_MSB = 7;
  localparam int unsigned DST_LSB = 4;
  localparam int unsigned TAG_MSB = 3;
  localparam int unsigned TAG_LSB = 0;

  // All-zero word is the traffic buffer's ROM padding, never a real flit.
  localparam logic [FLIT_W-1:0] NULL_FLIT = 20'h00000;

  function automatic logic [NODE_ID_W-1:0] flit_dest(input logic [FLIT_W-1:0] flit);
    return flit[DST_MSB:DST_LSB];
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic show-ahead synchronous FIFO; occupancy counter drives full/empty.
module noc_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/noc_inject_fifo.sv
// Injection stage: filters null/self-addressed flits, buffers the rest for the
// router's local port, and keeps saturating statistics.
module noc_inject_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FLIT_W  = noc_pkg::FLIT_W,
  parameter int unsigned NODE_ID = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic [FLIT_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            acc_cnt,
  output logic [7:0]             filt_cnt,
  output logic [7:0]             ovf_cnt,
  output logic                   src_err
);

  import noc_pkg::*;

  localparam logic [NODE_ID_W-1:0] NODE_DST = NODE_ID_W'(NODE_ID);
  localparam logic [SRC_W-1:0]     NODE_SRC = SRC_W'(NODE_ID);

  logic        is_null, is_self, cand;
  logic        push, pop, filt, ovf;
  logic [15:0] acc_cnt_q;
  logic [7:0]  filt_cnt_q, ovf_cnt_q;
  logic        src_err_q;

  assign is_null = (in_data == NULL_FLIT);
  assign is_self = (flit_dest(in_data) == NODE_DST);
  assign cand    = in_valid & ~is_null & ~is_self;
  assign filt    = in_valid & (is_null | is_self);

  // No bypass: pop needs a stored head, so an empty FIFO never pops.
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = cand & (~full | pop);
  assign ovf       = cand & full & ~pop;

  noc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (out_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q  <= '0;
      filt_cnt_q <= '0;
      ovf_cnt_q  <= '0;
      src_err_q  <= 1'b0;
    end else begin
      if (push && acc_cnt_q != 16'hFFFF) acc_cnt_q  <= acc_cnt_q + 1'b1;
      if (filt && filt_cnt_q != 8'hFF)   filt_cnt_q <= filt_cnt_q + 1'b1;
      if (ovf && ovf_cnt_q != 8'hFF)     ovf_cnt_q  <= ovf_cnt_q + 1'b1;
      if (push && in_data[SRC_MSB:SRC_LSB] != NODE_SRC) src_err_q <= 1'b1;
    end
  end

  assign acc_cnt  = acc_cnt_q;
  assign filt_cnt = filt_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign src_err  = src_err_q;

endmodule

// File: tb/tb_noc_inject_fifo.sv
// Directed self-checking bench for noc_inject_fifo (NODE_ID 13, DEPTH 8).
module tb_noc_inject_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [19:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        full, empty;
  logic [15:0] acc_cnt;
  logic [7:0]  filt_cnt, ovf_cnt;
  logic        src_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  noc_inject_fifo #(
    .DEPTH   (8),
    .FLIT_W  (20),
    .NODE_ID (13)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .acc_cnt   (acc_cnt),
    .filt_cnt  (filt_cnt),
    .ovf_cnt   (ovf_cnt),
    .src_err   (src_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_flit(input logic [19:0] f);
    in_data = f;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = '0;
  endtask

  // Valid test flit: src 0D, dest i (never 13 for i < 10), tag i.
  function automatic logic [19:0] vf(input int i);
    return {8'h0D, 4'h0, 4'(i), 4'(i)};
  endfunction

  logic [7:0]  stream_lo [15] = '{8'hFF, 8'hEE, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77,
                                   8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
  logic [19:0] exp_q [$];

  initial begin
    // Reset then idle
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_count", 32'(count), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_acc", 32'(acc_cnt), 0);
    check("rst_filt", 32'(filt_cnt), 0);
    check("rst_ovf", 32'(ovf_cnt), 0);
    check("rst_src_err", 32'(src_err), 0);

    // Asynchronous reset mid-burst with five entries held
    for (int i = 0; i < 5; i++) push_flit(vf(i));
    check("mid_count_before", 32'(count), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    tick();
    rst = 1'b0;

    // Streaming: each flit is the head one cycle after input
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = {8'h0D, 4'h0, stream_lo[i]};
      in_valid = 1'b1;
      tick();
      check($sformatf("stream_data_%0d", i), 32'(out_data), 32'({8'h0D, 4'h0, stream_lo[i]}));
      check($sformatf("stream_valid_%0d", i), 32'(out_valid), 1);
    end
    for (int i = 0; i < 15; i++) begin
      in_data = '0;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("stream_acc", 32'(acc_cnt), 15);
    check("stream_filt", 32'(filt_cnt), 15);
    check("stream_ovf", 32'(ovf_cnt), 0);
    check("stream_src_err", 32'(src_err), 0);
    check("stream_empty", 32'(empty), 1);

    // Self-addressed flit is filtered
    do_reset();
    push_flit(20'h0D0DD);
    check("self_filt", 32'(filt_cnt), 1);
    check("self_acc", 32'(acc_cnt), 0);
    check("self_out_valid", 32'(out_valid), 0);

    // Fill to DEPTH with router stalled, then overflow two flits
    do_reset();
    for (int i = 0; i < 8; i++) push_flit(vf(i));
    check("fill_count", 32'(count), 8);
    check("fill_full", 32'(full), 1);
    push_flit(vf(8));
    push_flit(vf(9));
    check("fill_ovf", 32'(ovf_cnt), 2);
    check("fill_acc", 32'(acc_cnt), 8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_data_%0d", i), 32'(out_data), 32'(vf(i)));
      tick();
    end
    check("drain_empty", 32'(empty), 1);

    // Full with a simultaneous pop: slot is reused, no overflow
    do_reset();
    for (int i = 0; i < 8; i++) push_flit(vf(i));
    out_ready = 1'b1;
    push_flit(20'h0D0AB);
    out_ready = 1'b0;
    check("fullpop_count", 32'(count), 8);
    check("fullpop_ovf", 32'(ovf_cnt), 0);
    check("fullpop_acc", 32'(acc_cnt), 9);
    exp_q.delete();
    for (int i = 1; i < 8; i++) exp_q.push_back(vf(i));
    exp_q.push_back(20'h0D0AB);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fullpop_data_%0d", i), 32'(out_data), 32'(exp_q[i]));
      tick();
    end
    check("fullpop_empty", 32'(empty), 1);

    // Foreign source is accepted but flagged; overflow counter saturates
    do_reset();
    push_flit(20'h0C0FF);
    check("src_err_set", 32'(src_err), 1);
    check("src_err_acc", 32'(acc_cnt), 1);
    check("src_err_head", 32'(out_data), 32'h0C0FF);
    for (int i = 0; i < 7; i++) push_flit(vf(i));
    for (int i = 0; i < 300; i++) push_flit(vf(i % 10));
    check("sat_ovf", 32'(ovf_cnt), 32'hFF);
    check("sat_count", 32'(count), 8);
    check("sat_acc", 32'(acc_cnt), 8);
    check("src_err_sticky", 32'(src_err), 1);
    do_reset();
    check("src_err_cleared", 32'(src_err), 0);
    check("ovf_cleared", 32'(ovf_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
